// File: rtl/mem_loader_if.sv
// mem_loader_if: byte stream, CPU pass-through, memory port and status bundle for mem_loader.
interface mem_loader_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic [14:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_load;
  logic        busy;
  logic        done;
  logic        error;
  logic [14:0] word_count;
  modport master (
    output start, byte_in, byte_valid, cpu_addr, cpu_in, cpu_load,
    input  byte_ready, mem_addr, mem_in, mem_load, busy, done, error, word_count
  );
  modport slave (
    input  start, byte_in, byte_valid, cpu_addr, cpu_in, cpu_load,
    output byte_ready, mem_addr, mem_in, mem_load, busy, done, error, word_count
  );
endinterface

// File: rtl/mem_loader.sv
// mem_loader: boot loader assembling big-endian words from a byte stream into memory.
// Define MEM_LOADER_CHECKSUM_EN to require a trailing 16-bit word-sum checksum.
module mem_loader #(
  parameter logic [14:0] BASE_ADDR = 15'h0000,
  parameter logic [14:0] MEM_TOP   = 15'h6000
) (
  input logic        clk,
  input logic        rst_n,
  mem_loader_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO,
    S_WRITE, S_CSUM_HI, S_CSUM_LO, S_DONE, S_ERROR
  } state_t;
  localparam logic [16:0] LIMIT = {2'b00, MEM_TOP} - {2'b00, BASE_ADDR} + 17'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM_HI;
  logic [15:0] r_sum;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  state_t      r_state, w_nxt;
  logic        r_ready, r_busy, r_done, r_error;
  logic [7:0]  r_hi;
  logic [15:0] r_len, r_word;
  logic [14:0] r_cnt;
  logic        w_xfer, w_idle, w_last;
  logic [15:0] w_byte;
  assign w_xfer = bus.byte_valid & r_ready;
  assign w_byte = {r_hi, bus.byte_in};
  assign w_idle = r_state inside {S_IDLE, S_DONE, S_ERROR};
  assign w_last = ({1'b0, r_cnt} + 16'd1) == r_len;
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: w_nxt = bus.start ? S_LEN_HI : r_state;
      S_LEN_HI:  w_nxt = w_xfer ? S_LEN_LO : r_state;
      S_LEN_LO:  w_nxt = !w_xfer ? r_state : ({1'b0, w_byte} > LIMIT) ? S_ERROR :
                         (w_byte == 16'd0) ? S_FIN : S_DATA_HI;
      S_DATA_HI: w_nxt = w_xfer ? S_DATA_LO : r_state;
      S_DATA_LO: w_nxt = w_xfer ? S_WRITE : r_state;
      S_WRITE:   w_nxt = w_last ? S_FIN : S_DATA_HI;
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CSUM_HI: w_nxt = w_xfer ? S_CSUM_LO : r_state;
      S_CSUM_LO: w_nxt = !w_xfer ? r_state : (w_byte == r_sum) ? S_DONE : S_ERROR;
`endif
      default:   w_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_hi    <= 8'd0;
      r_len   <= 16'd0;
      r_word  <= 16'd0;
      r_cnt   <= 15'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
      r_sum   <= 16'd0;
`endif
    end else begin
      r_state <= w_nxt;
      r_ready <= w_nxt inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO};
      r_busy  <= !(w_nxt inside {S_IDLE, S_DONE, S_ERROR});
      r_done  <= w_nxt == S_DONE;
      r_error <= w_nxt == S_ERROR;
      if (w_xfer) r_hi <= bus.byte_in;
      if (w_xfer && r_state == S_LEN_LO) r_len <= w_byte;
      if (w_xfer && r_state == S_DATA_LO) r_word <= w_byte;
      if (w_idle && bus.start) r_cnt <= 15'd0;
      if (r_state == S_WRITE) r_cnt <= r_cnt + 15'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
      if (w_idle && bus.start) r_sum <= 16'd0;
      if (r_state == S_WRITE) r_sum <= r_sum + r_word;
`endif
    end
  end
  assign bus.byte_ready = r_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.word_count = r_cnt;
  assign bus.mem_addr   = r_busy ? BASE_ADDR + r_cnt : bus.cpu_addr;
  assign bus.mem_in     = r_busy ? r_word : bus.cpu_in;
  // rst_n gating keeps a stray CPU write from reaching memory during reset
  assign bus.mem_load   = rst_n & (r_busy ? (r_state == S_WRITE) : bus.cpu_load);
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench; expected writes are queued by stimulus and popped by a write monitor.
module tb_mem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mem_loader_if bus();
  mem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int writes = 0;
  int w0;
  logic [30:0] exp_q[$];
  logic [30:0] e;
  logic [15:0] mem [0:63];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.busy && bus.mem_load) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h with no write expected", bus.mem_addr, bus.mem_in);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {17'd0, bus.mem_addr}, {17'd0, e[30:16]});
        chk("write_data", {16'd0, bus.mem_in}, {16'd0, e[15:0]});
        if (bus.mem_addr < 15'd64) mem[bus.mem_addr[5:0]] = bus.mem_in;
      end
    end
  end
  task automatic expect_word(input logic [14:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accept", {31'd0, n < 50}, 32'd1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask
  task automatic send_bytes(input logic [63:0] v, input int n, input bit rnd);
    for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8], rnd ? int'($urandom_range(0, 3)) : 0);
  endtask
  task automatic send_csum(input logic [15:0] s);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_bytes({48'd0, s}, 2, 1'b0);
`else
    bus.byte_valid = 1'b0;
    bus.byte_in = s[7:0];
`endif
  endtask
  task automatic start_load();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, n < 200}, 32'd1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.byte_in = 8'd0;
    bus.byte_valid = 1'b0;
    bus.cpu_addr = 15'd0;
    bus.cpu_in = 16'd0;
    bus.cpu_load = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_error", {31'd0, bus.error}, 32'd0);
    chk("rst_word_count", {17'd0, bus.word_count}, 32'd0);
    chk("rst_mem_load", {31'd0, bus.mem_load}, 32'd0);
    bus.cpu_load = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    // two-word load
    expect_word(15'd0, 16'h1234);
    expect_word(15'd1, 16'hABCD);
    start_load();
    send_bytes(64'h0000_0002_1234_ABCD, 6, 1'b0);
    send_csum(16'hBE01);
    wait_idle();
    chk("t1_done", {31'd0, bus.done}, 32'd1);
    chk("t1_error", {31'd0, bus.error}, 32'd0);
    chk("t1_word_count", {17'd0, bus.word_count}, 32'd2);
    chk("t1_mem0", {16'd0, mem[0]}, 32'h1234);
    chk("t1_mem1", {16'd0, mem[1]}, 32'hABCD);
    chk("t1_queue", exp_q.size(), 32'd0);
    // empty stream
    w0 = writes;
    start_load();
    send_bytes(64'h0000, 2, 1'b0);
    send_csum(16'h0000);
    wait_idle();
    chk("t2_writes", writes, w0);
    chk("t2_done", {31'd0, bus.done}, 32'd1);
    chk("t2_word_count", {17'd0, bus.word_count}, 32'd0);
    // oversize length
    w0 = writes;
    start_load();
    send_bytes(64'h6002, 2, 1'b0);
    wait_idle();
    chk("t3_error", {31'd0, bus.error}, 32'd1);
    chk("t3_done", {31'd0, bus.done}, 32'd0);
    chk("t3_writes", writes, w0);
    chk("t3_ready", {31'd0, bus.byte_ready}, 32'd0);
    start_load();
    chk("t3_error_cleared", {31'd0, bus.error}, 32'd0);
    chk("t3_busy", {31'd0, bus.busy}, 32'd1);
    chk("t3_len_ready", {31'd0, bus.byte_ready}, 32'd1);
    expect_word(15'd0, 16'h0007);
    send_bytes(64'h0001_0007, 4, 1'b0);
    send_csum(16'h0007);
    wait_idle();
    chk("t3_done_after", {31'd0, bus.done}, 32'd1);
    chk("t3_word_count", {17'd0, bus.word_count}, 32'd1);
    // random valid, reset after third word
    w0 = writes;
    expect_word(15'd0, 16'h1111);
    expect_word(15'd1, 16'h2222);
    expect_word(15'd2, 16'h3333);
    start_load();
    send_bytes(64'h0005_1111_2222_3333, 8, 1'b1);
    for (int n = 0; n < 20 && writes < w0 + 3; n++) @(negedge clk);
    chk("t4_writes_before_rst", writes, w0 + 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4_rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("t4_rst_word_count", {17'd0, bus.word_count}, 32'd0);
    chk("t4_rst_mem_load", {31'd0, bus.mem_load}, 32'd0);
    rst_n = 1'b1;
    bus.byte_in = 8'h44;
    bus.byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("t4_writes_after_rst", writes, w0 + 3);
    chk("t4_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4_idle_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("t4_queue", exp_q.size(), 32'd0);
    // CPU pass-through and isolation while loading
    bus.cpu_addr = 15'h0010;
    bus.cpu_in = 16'h5555;
    bus.cpu_load = 1'b1;
    #1;
    chk("t5_pass_addr", {17'd0, bus.mem_addr}, 32'h0010);
    chk("t5_pass_data", {16'd0, bus.mem_in}, 32'h5555);
    chk("t5_pass_load", {31'd0, bus.mem_load}, 32'd1);
    @(negedge clk);
    start_load();
    chk("t5_busy_load", {31'd0, bus.mem_load}, 32'd0);
    chk("t5_busy_addr", {17'd0, bus.mem_addr}, 32'd0);
    expect_word(15'd0, 16'hBEEF);
    send_bytes(64'h0001_BEEF, 4, 1'b0);
    send_csum(16'hBEEF);
    wait_idle();
    chk("t5_done", {31'd0, bus.done}, 32'd1);
    chk("t5_back_addr", {17'd0, bus.mem_addr}, 32'h0010);
    chk("t5_back_load", {31'd0, bus.mem_load}, 32'd1);
    bus.cpu_load = 1'b0;
    @(negedge clk);
`ifdef MEM_LOADER_CHECKSUM_EN
    expect_word(15'd0, 16'h0001);
    expect_word(15'd1, 16'h0002);
    start_load();
    send_bytes(64'h0002_0001_0002_0004, 8, 1'b0);
    wait_idle();
    chk("t6_bad_error", {31'd0, bus.error}, 32'd1);
    chk("t6_bad_done", {31'd0, bus.done}, 32'd0);
    chk("t6_bad_word_count", {17'd0, bus.word_count}, 32'd2);
    expect_word(15'd0, 16'h0001);
    expect_word(15'd1, 16'h0002);
    start_load();
    send_bytes(64'h0002_0001_0002_0003, 8, 1'b0);
    wait_idle();
    chk("t6_good_done", {31'd0, bus.done}, 32'd1);
    chk("t6_good_error", {31'd0, bus.error}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    chk("final_queue", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
